// File: rtl/seq_datapath_pkg.sv
// rtl/seq_datapath_pkg.sv - command encodings and FSM state type for seq_datapath
package seq_datapath_pkg;

    typedef enum logic [1:0] {
        MODE_ALU = 2'b00,
        MODE_CMP = 2'b01,
        MODE_MOV = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_AND  = 2'b10,
        OP_NOTB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL1 = 2'b01,
        SH_LSR1 = 2'b10,
        SH_ASR1 = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

    localparam int STATUS_W = 3;

    // Only ALU and move commands commit to the register file.
    function automatic logic mode_writes(input mode_e mode);
        return (mode == MODE_ALU) || (mode == MODE_MOV);
    endfunction

endpackage

// File: rtl/sd_regfile.sv
// rtl/sd_regfile.sv - register file: one synchronous write port, two combinational read ports
module sd_regfile #(
    parameter int  WIDTH = 16,
    parameter int  NREGS = 8,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/seq_datapath.sv
// rtl/seq_datapath.sv - multi-cycle register/ALU datapath sequenced by a five-state FSM
module seq_datapath
    import seq_datapath_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  NREGS = 8,
    parameter int  IMMW  = 5,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [1:0]          cmd_op,
    input  logic [1:0]          cmd_shift,
    input  logic                cmd_asel,
    input  logic                cmd_bsel,
    input  logic [AW-1:0]       cmd_rn,
    input  logic [AW-1:0]       cmd_rm,
    input  logic [AW-1:0]       cmd_rd,
    input  logic [IMMW-1:0]     cmd_imm,
    input  logic [WIDTH-1:0]    wr_data,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic [STATUS_W-1:0] status,
    output logic                busy,
    input  logic [AW-1:0]       dbg_addr,
    output logic [WIDTH-1:0]    dbg_data
);

    state_e state_q, state_d;

    mode_e                mode_q;
    op_e                  op_q;
    shift_e               shift_q;
    logic                 asel_q, bsel_q;
    logic [AW-1:0]        rn_q, rm_q, rd_q;
    logic [IMMW-1:0]      imm_q;
    logic [WIDTH-1:0]     a_q, b_q, c_q;
    logic [STATUS_W-1:0]  status_q;

    logic                 accept;
    logic [AW-1:0]        rf_raddr;
    logic [WIDTH-1:0]     rf_rdata;
    logic                 rf_we;

    logic [WIDTH-1:0]     a_op, b_sh, b_op, imm_ext, alu_res;
    logic                 alu_v;

    // Operand A and B are fetched in different states, so one read port serves both.
    assign rf_raddr = (state_q == S_RDB) ? rm_q : rn_q;
    assign rf_we    = (state_q == S_WB) && mode_writes(mode_q);

    sd_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (c_q),
        .raddr_a (rf_raddr),
        .rdata_a (rf_rdata),
        .raddr_b (dbg_addr),
        .rdata_b (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = (mode_e'(cmd_mode) == MODE_MOV) ? S_WB : S_RDA;
                end
            end
            S_RDA:  state_d = S_RDB;
            S_RDB:  state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imm_ext = {{(WIDTH-IMMW){1'b0}}, imm_q};

    always_comb begin
        a_op    = asel_q ? '0 : a_q;
        b_sh    = b_q;
        alu_res = '0;
        alu_v   = 1'b0;
        case (shift_q)
            SH_LSL1: b_sh = {b_q[WIDTH-2:0], 1'b0};
            SH_LSR1: b_sh = {1'b0, b_q[WIDTH-1:1]};
            SH_ASR1: b_sh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: b_sh = b_q;
        endcase
        b_op = bsel_q ? imm_ext : b_sh;
        case (op_q)
            OP_ADD: begin
                alu_res = a_op + b_op;
                alu_v   = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a_op - b_op;
                alu_v   = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
            end
            OP_AND:  alu_res = a_op & b_op;
            default: alu_res = ~b_op;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_ALU;
            op_q     <= OP_ADD;
            shift_q  <= SH_NONE;
            asel_q   <= 1'b0;
            bsel_q   <= 1'b0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
        end else begin
            if (accept) begin
                mode_q  <= mode_e'(cmd_mode);
                op_q    <= op_e'(cmd_op);
                shift_q <= shift_e'(cmd_shift);
                asel_q  <= cmd_asel;
                bsel_q  <= cmd_bsel;
                rn_q    <= cmd_rn;
                rm_q    <= cmd_rm;
                rd_q    <= cmd_rd;
                imm_q   <= cmd_imm;
                // A move goes straight to write-back, so C captures its data at the handshake.
                if (mode_e'(cmd_mode) == MODE_MOV) begin
                    c_q <= wr_data;
                end
            end
            if (state_q == S_RDA) begin
                a_q <= rf_rdata;
            end
            if (state_q == S_RDB) begin
                b_q <= rf_rdata;
            end
            if (state_q == S_EXEC) begin
                c_q      <= alu_res;
                status_q <= {alu_res[WIDTH-1], alu_v, (alu_res == '0)};
            end
        end
    end

    assign result = c_q;
    assign status = status_q;

endmodule
